posit_out_encoder: RTL
======================

Name: posit_out_encoder

Overview:
- Downstream stage of the fraction/scale-factor normaliser in the posit MAC datapath.
- Consumes the normalised result: sign, ovf, udf, nzero, signed scale factor and 1.f mantissa.
- Produces a WIDTH-bit posit word (es=EXP) using round-to-nearest-even and posit saturation.
- Two-stage pipeline with a valid/ready handshake on both sides, so the output writeback can apply backpressure.

Parameters:
- WIDTH, 8, posit word width.
- EXP, 2, posit exponent field width (es).
- MTS, WIDTH-3-EXP, per-operand fraction width; the input mantissa is 2*MTS+2 bits.
- REGI, $clog2(WIDTH)+1, regime count width; the scale factor is REGI+EXP+1 bits signed.

Ports:
- clk_i  in  1  clock. One clock domain, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_vld_i  in  1  input beat valid.
- in_rdy_o  out  1  block can accept an input beat.
- sign_i  in  1  result sign.
- ovf_i  in  1  magnitude overflow.
- udf_i  in  1  magnitude underflow.
- nzero_i  in  1  0 means the result is exactly zero.
- sf_i  in  REGI+EXP+1  signed scale factor.
- mts_i  in  2*MTS+2  mantissa in 1.f format; the MSB is the hidden one.
- out_vld_o  out  1  posit_o valid.
- out_rdy_i  in  1  consumer accepts posit_o.
- posit_o  out  WIDTH  encoded posit.

Behaviour:
- Reset: while rst is high, all state clears asynchronously. out_vld_o=0, posit_o=0, all stage valids 0. in_rdy_o=1 once reset is released.
- Transfer rule: a beat moves across an interface when vld&rdy are both high in the same cycle.
  - en2 = ~s2_vld | out_rdy_i
  - en1 = ~s1_vld | en2
  - in_rdy_o = en1 (combinational)
- Latency: 2 cycles from input accept to out_vld_o when there is no stall.
- Throughput: 1 beat per cycle.
- Under stall, registered data holds stable and no beat is dropped or duplicated.
- Stage 1 (registered on en1):
  - Classify the beat:
    - ZERO when nzero_i=0.
    - SAT_MAX when ovf_i=1, or when sf_i > maxsf, where maxsf = (WIDTH-2)*2^EXP.
    - SAT_MIN when udf_i=1 with nzero_i=1, or when sf_i < -maxsf.
    - NORM otherwise.
  - Priority when flags overlap: ZERO > SAT_MAX > SAT_MIN.
  - Split the scale factor: k = sf_i >>> EXP (arithmetic shift); e = sf_i[EXP-1:0].
  - Regime encoding:
    - k>=0: k+1 ones, then a zero.
    - k<0: -k zeros, then a one.
  - Build the unsigned body as regime, then e, then the fraction mts_i[2*MTS:0], left-aligned into WIDTH-1 bits.
  - Register the guard bit and the sticky OR of all remaining bits.
  - The regime length clamps at WIDTH-1 bits. Fields that do not fit are truncated into guard/sticky.
- Stage 2 (registered on en2):
  - Round to nearest, ties to even: increment when guard & (sticky | lsb).
  - If rounding would carry to 2^(WIDTH-1), clamp to maxpos 0111..1.
  - A NORM beat never rounds to 0; it clamps to minpos 000..01.
  - Fixed encodings:
    - SAT_MAX = 0 followed by all ones.
    - SAT_MIN = 0..01.
    - ZERO = all zeros.
  - If sign=1 and the result is non-zero, posit_o = two's complement of the magnitude.
  - A ZERO beat outputs all zeros regardless of sign.
  - NaR (1000..0) is never produced.
- Simultaneous events: a new beat accepted in the same cycle as the output drains takes the freed slot; full throughput must be sustained.
- Reset mid-stream: in-flight beats are discarded and out_vld_o drops immediately.

Decomposition:
- Package posit_pkg holds:
  - WIDTH, EXP, MTS, REGI defaults.
  - Derived MAXSF.
  - Constants POSIT_MAXPOS, POSIT_MINPOS, POSIT_ZERO.
  - A 2-bit class enum {ZERO, SAT_MAX, SAT_MIN, NORM}.
- Sub-module posit_rne_round is natural for the stage-2 logic. It is combinational and takes body, guard and sticky, returning the rounded and saturated magnitude. It is reusable by the MAC input decoder tests.

Test Plan (WIDTH=8, EXP=2, MTS=3; mantissa is 8 bits):
- One: sf=0, mts=8'h80, sign=0 -> posit_o=8'h40 two cycles after accept. With sign=1 -> 8'hC0.
- Field packing: sf=5, mts=8'hC0 -> 8'h66. Check: regime 110, exp 01, frac 10.
- RNE tie to even:
  - sf=0, mts=8'h88 -> 8'h40 (tie, lsb even, no increment).
  - sf=0, mts=8'h98 -> 8'h42 (tie, lsb odd, increment).
- Saturation and flags:
  - ovf=1, sign=1 -> 8'h81.
  - sf=30 -> 8'h7F.
  - udf=1, nzero=1 -> 8'h01.
  - sf=-30 -> 8'h01.
  - nzero=0 with sign=1 -> 8'h00.
- Backpressure:
  - Drive 5 back-to-back beats; hold out_rdy_i=0 for 3 cycles after the first out_vld_o.
  - Expect in_rdy_o=0 once both stages are full, posit_o stable while stalled, all 5 results in order, none lost.
- Reset mid-stream: assert rst with 2 beats in flight -> out_vld_o=0 in the same cycle. After release, one beat (sf=0, mts=8'h80) -> 8'h40 only.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared definitions for the posit output path: default geometry, fixed encodings
// and the beat classification used between the encoder stages.
package posit_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_EXP   = 2;
  localparam int DEF_MTS   = DEF_WIDTH - 3 - DEF_EXP;
  localparam int DEF_REGI  = $clog2(DEF_WIDTH) + 1;
  localparam int DEF_MAXSF = (DEF_WIDTH - 2) * (2 ** DEF_EXP);

  localparam logic [DEF_WIDTH-1:0] POSIT_MAXPOS = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] POSIT_MINPOS = {{(DEF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DEF_WIDTH-1:0] POSIT_ZERO   = {DEF_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    CLS_ZERO    = 2'd0,
    CLS_SAT_MAX = 2'd1,
    CLS_SAT_MIN = 2'd2,
    CLS_NORM    = 2'd3
  } posit_cls_e;

endpackage

// File: rtl/posit_rne_round.sv
// Round-to-nearest-even on an unsigned posit body, saturating to maxpos on carry-out
// and never collapsing a non-zero value to zero.
module posit_rne_round #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-2:0] i_body,
  input  logic             i_guard,
  input  logic             i_sticky,
  output logic [WIDTH-1:0] o_mag
);

  logic             w_inc;
  logic [WIDTH-1:0] w_sum;

  // Increment on guard unless it is an exact tie with an even lsb
  always_comb begin
    w_inc = i_guard & (i_sticky | i_body[0]);
    w_sum = {1'b0, i_body} + {{(WIDTH-1){1'b0}}, w_inc};
    if (w_sum[WIDTH-1]) begin
      o_mag = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (w_sum == {WIDTH{1'b0}}) begin
      o_mag = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      o_mag = w_sum;
    end
  end

endmodule

// File: rtl/posit_out_encoder.sv
// Two-stage posit encoder: stage 1 packs regime/exponent/fraction with guard and
// sticky, stage 2 rounds, saturates and applies the sign, behind valid/ready.
module posit_out_encoder
  import posit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP   = DEF_EXP,
  parameter int MTS   = WIDTH - 3 - EXP,
  parameter int REGI  = $clog2(WIDTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  in_vld_i,
  output logic                  in_rdy_o,
  input  logic                  sign_i,
  input  logic                  ovf_i,
  input  logic                  udf_i,
  input  logic                  nzero_i,
  input  logic [REGI+EXP:0]     sf_i,
  input  logic [2*MTS+1:0]      mts_i,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i,
  output logic [WIDTH-1:0]      posit_o
);

  localparam int SFW   = REGI + EXP + 1;
  localparam int XW    = WIDTH + EXP + 2*MTS + 1;
  localparam int PAD   = WIDTH - 2;
  localparam int SHW   = $clog2(WIDTH);
  localparam int MAXSF = (WIDTH - 2) * (2 ** EXP);

  localparam logic signed [SFW-1:0] SF_MAX  = SFW'(MAXSF);
  localparam logic signed [SFW-1:0] SF_MIN  = -SF_MAX;
  localparam logic        [SFW-1:0] RUN_MAX = SFW'(WIDTH - 2);
  localparam logic      [WIDTH-1:0] MAXPOS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic      [WIDTH-1:0] MINPOS  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic      [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic                  w_en1;
  logic                  w_en2;
  logic signed [SFW-1:0] w_sf;
  logic signed [SFW-1:0] w_k;
  logic        [SFW-1:0] w_run;
  logic        [SHW-1:0] w_amt;
  logic signed [XW-1:0]  w_x;
  logic signed [XW-1:0]  w_sh;
  posit_cls_e            w_cls;
  logic      [WIDTH-1:0] w_round;
  logic      [WIDTH-1:0] w_mag;
  logic      [WIDTH-1:0] w_posit;
  logic                  w_unused_hidden;

  logic                  r_s1_vld;
  posit_cls_e            r_s1_cls;
  logic                  r_s1_sign;
  logic      [WIDTH-2:0] r_s1_body;
  logic                  r_s1_guard;
  logic                  r_s1_sticky;
  logic                  r_s2_vld;
  logic      [WIDTH-1:0] r_posit;

  assign w_en2           = ~r_s2_vld | out_rdy_i;
  assign w_en1           = ~r_s1_vld | w_en2;
  assign in_rdy_o        = w_en1;
  assign out_vld_o       = r_s2_vld;
  assign posit_o         = r_posit;
  assign w_unused_hidden = mts_i[2*MTS+1];

  // Stage-1 classification and field packing; the regime is produced by an
  // arithmetic shift that replicates the leading run bit.
  always_comb begin
    w_sf = $signed(sf_i);
    w_k  = w_sf >>> EXP;
    if (w_k[SFW-1]) begin
      w_x   = {2'b01, sf_i[EXP-1:0], mts_i[2*MTS:0], {PAD{1'b0}}};
      w_run = ~w_k;
    end else begin
      w_x   = {2'b10, sf_i[EXP-1:0], mts_i[2*MTS:0], {PAD{1'b0}}};
      w_run = w_k;
    end
    if (w_run > RUN_MAX) begin
      w_amt = RUN_MAX[SHW-1:0];
    end else begin
      w_amt = w_run[SHW-1:0];
    end
    w_sh = w_x >>> w_amt;
    if (!nzero_i) begin
      w_cls = CLS_ZERO;
    end else if (ovf_i || (w_sf > SF_MAX)) begin
      w_cls = CLS_SAT_MAX;
    end else if (udf_i || (w_sf < SF_MIN)) begin
      w_cls = CLS_SAT_MIN;
    end else begin
      w_cls = CLS_NORM;
    end
  end

  // Stage-1 register
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_cls    <= CLS_ZERO;
      r_s1_sign   <= 1'b0;
      r_s1_body   <= {(WIDTH-1){1'b0}};
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
    end else if (w_en1) begin
      r_s1_vld    <= in_vld_i;
      r_s1_cls    <= w_cls;
      r_s1_sign   <= sign_i;
      r_s1_body   <= w_sh[XW-1 -: WIDTH-1];
      r_s1_guard  <= w_sh[XW-WIDTH];
      r_s1_sticky <= |w_sh[XW-WIDTH-1:0];
    end
  end

  posit_rne_round #(
    .WIDTH (WIDTH)
  ) u_round (
    .i_body   (r_s1_body),
    .i_guard  (r_s1_guard),
    .i_sticky (r_s1_sticky),
    .o_mag    (w_round)
  );

  // Stage-2 magnitude selection and sign application
  always_comb begin
    case (r_s1_cls)
      CLS_ZERO:    w_mag = {WIDTH{1'b0}};
      CLS_SAT_MAX: w_mag = MAXPOS;
      CLS_SAT_MIN: w_mag = MINPOS;
      CLS_NORM:    w_mag = w_round;
      default:     w_mag = {WIDTH{1'b0}};
    endcase
    if (r_s1_sign && (w_mag != {WIDTH{1'b0}})) begin
      w_posit = (~w_mag) + ONE;
    end else begin
      w_posit = w_mag;
    end
  end

  // Stage-2 output register
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_s2_vld <= 1'b0;
      r_posit  <= {WIDTH{1'b0}};
    end else if (w_en2) begin
      r_s2_vld <= r_s1_vld;
      r_posit  <= w_posit;
    end
  end

endmodule
